// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator: emits a commanded number of
// Gray-code edges on A/B at a fixed rate and tracks signed position.
module quad_encoder_gen #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       dir_in,
  input  logic [CNT_W-1:0] steps,
  input  logic             abort,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div;
  logic [CNT_W-1:0] r_rem;
  logic             r_fwd;
  logic [1:0]       r_ab;
  logic [CNT_W-1:0] r_pos;
  logic             r_done;

  state_t           w_state;
  logic [DW-1:0]    w_div;
  logic [CNT_W-1:0] w_rem;
  logic             w_fwd;
  logic [1:0]       w_ab;
  logic [CNT_W-1:0] w_pos;
  logic             w_done;
  logic             w_cmd_ok;

  assign w_cmd_ok = start
                  && (dir_in == 2'b01 || dir_in == 2'b10)
                  && (steps != '0);

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_rem   = r_rem;
    w_fwd   = r_fwd;
    w_ab    = r_ab;
    w_pos   = r_pos;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cmd_ok) begin
          w_state = RUN;
          w_fwd   = dir_in[0];
          w_rem   = steps;
          w_div   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          w_state = IDLE;
          w_div   = '0;
        end else if (r_div == DIV_LAST) begin
          // Forward rotates {A,B} -> {~B,A}; reverse -> {B,~A}
          w_ab  = r_fwd ? {~r_ab[0], r_ab[1]}
                        : {r_ab[0], ~r_ab[1]};
          w_pos = r_fwd ? r_pos + CNT_W'(1)
                        : r_pos - CNT_W'(1);
          w_rem = r_rem - CNT_W'(1);
          w_div = '0;
          if (r_rem == CNT_W'(1)) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end
        end else begin
          w_div = r_div + DW'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_rem   <= '0;
      r_fwd   <= 1'b0;
      r_ab    <= 2'b00;
      r_pos   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_rem   <= w_rem;
      r_fwd   <= w_fwd;
      r_ab    <= w_ab;
      r_pos   <= w_pos;
      r_done  <= w_done;
    end
  end

  assign A    = r_ab[1];
  assign B    = r_ab[0];
  assign busy = (r_state == RUN);
  assign done = r_done;
  assign pos  = r_pos;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: a DIV=4 unit for sequencing
// and a DIV=1 unit for position wrap-around.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  dir_in = 2'b00;
  logic [15:0] steps = '0;
  logic        abort = 1'b0;
  logic        A, B, busy, done;
  logic [15:0] pos;

  logic        rst1_n = 1'b0;
  logic        start1 = 1'b0;
  logic [1:0]  dir1 = 2'b00;
  logic [15:0] steps1 = '0;
  logic        abort1 = 1'b0;
  logic        A1, B1, busy1, done1;
  logic [15:0] pos1;

  int n_vec = 0;
  int n_err = 0;

  quad_encoder_gen #(.DIV(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir_in(dir_in),
    .steps(steps), .abort(abort), .A(A), .B(B), .busy(busy),
    .done(done), .pos(pos)
  );

  quad_encoder_gen #(.DIV(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .dir_in(dir1),
    .steps(steps1), .abort(abort1), .A(A1), .B(B1), .busy(busy1),
    .done(done1), .pos(pos1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run on the DIV=4 unit; returns after the accepting edge
  task automatic cmd(input logic [1:0] d, input logic [15:0] n);
    start  = 1'b1;
    dir_in = d;
    steps  = n;
    tick();
    start  = 1'b0;
  endtask

  logic [1:0] fseq [5];
  logic [1:0] rseq [7];
  logic [1:0] mseq [3];
  int cyc;

  initial begin
    fseq = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    rseq = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    mseq = '{2'b11, 2'b01, 2'b00};

    tick();
    tick();
    chk("rst_ab", {A, B}, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", pos, 0);
    rst_n = 1'b1;
    rst1_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Forward 4 steps
    cmd(2'b01, 16'd4);
    chk("fwd_busy", busy, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("fwd_ab%0d", i), {A, B}, fseq[i/4]);
      chk($sformatf("fwd_done%0d", i), done, (i == 16));
      chk($sformatf("fwd_busy%0d", i), busy, (i != 16));
    end
    chk("fwd_pos", pos, 16'd4);
    tick();
    chk("fwd_done_clr", done, 0);

    // Reverse 6 steps from 00
    cmd(2'b10, 16'd6);
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk($sformatf("rev_ab%0d", i), {A, B}, rseq[i/4]);
      chk($sformatf("rev_done%0d", i), done, (i == 24));
    end
    chk("rev_pos", pos, 16'hFFFE);
    tick();

    // Ignored commands
    cmd(2'b01, 16'd0);
    chk("ign0_busy", busy, 0);
    chk("ign0_done", done, 0);
    cmd(2'b11, 16'd3);
    chk("ign11_busy", busy, 0);
    cmd(2'b00, 16'd3);
    chk("ign00_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_done", done, 0);
      chk("ign_ab", {A, B}, 2'b11);
    end

    // Start pulsed mid-run is ignored (from 11, forward 2)
    cmd(2'b01, 16'd2);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        start = 1'b1; dir_in = 2'b10; steps = 16'd9;
      end
      tick();
      start = 1'b0;
      chk($sformatf("mid_ab%0d", i), {A, B}, mseq[i/4]);
      chk($sformatf("mid_done%0d", i), done, (i == 8));
    end
    chk("mid_pos", pos, 16'h0000);
    tick();
    chk("mid_busy_after", busy, 0);

    // Abort at the 4th terminal count (from 00, pos 0)
    cmd(2'b01, 16'd10);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("ab_ab%0d", i), {A, B}, fseq[i/4]);
    end
    chk("ab_busy_pre", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_ab", {A, B}, 2'b01);
    chk("ab_pos", pos, 16'd3);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ab_hold", {A, B}, 2'b01);
      chk("ab_nodone", done, 0);
    end

    // Start with abort in IDLE: accepted, one step 01 -> 00
    abort = 1'b1;
    cmd(2'b01, 16'd1);
    abort = 1'b0;
    chk("sa_busy", busy, 1);
    for (int i = 1; i <= 4; i++) tick();
    chk("sa_done", done, 1);
    chk("sa_ab", {A, B}, 2'b00);
    chk("sa_pos", pos, 16'd4);
    tick();

    // Reset mid-run after 2 edges (00 -> 10 -> 11)
    cmd(2'b01, 16'd10);
    for (int i = 1; i <= 8; i++) tick();
    chk("mr_ab_pre", {A, B}, 2'b11);
    chk("mr_pos_pre", pos, 16'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_ab", {A, B}, 2'b00);
    chk("mr_pos", pos, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mr_hold", {A, B}, 2'b00);
      chk("mr_idle", busy, 0);
    end

    // DIV=1: wrap 0x7FFF -> 0x8000
    start1 = 1'b1; dir1 = 2'b01; steps1 = 16'd32767;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 40000) begin
      tick();
      cyc++;
    end
    chk("w_cycles", cyc, 32767);
    chk("w_pos7fff", pos1, 16'h7FFF);
    chk("w_ab7fff", {A1, B1}, 2'b01);
    tick();
    start1 = 1'b1; dir1 = 2'b01; steps1 = 16'd1;
    tick();
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    tick();
    chk("w1_done", done1, 1);
    chk("w_pos8000", pos1, 16'h8000);
    chk("w_ab8000", {A1, B1}, 2'b00);
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    start1 = 1'b1; dir1 = 2'b10; steps1 = 16'd1;
    tick();
    start1 = 1'b0;
    tick();
    chk("wr_done", done1, 1);
    chk("wr_posffff", pos1, 16'hFFFF);
    chk("wr_ab", {A1, B1}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
